// File: rtl/fifo_stat_monitor.sv
// fifo_stat_monitor
//   Observes the write/read strobes of NUM_CH FIFOs. For each channel it keeps
//   the live occupancy, the cycles since the last write (gap), a high-water
//   mark and two saturating histograms sampled on each write: one of the gap
//   length and one of the occupancy at the time of the write.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   run_program         program run request (with !active_program: start)
//   active_program      program executing; gates gap counting and sampling
//   end_program         program end pulse; zeroes the gap counters
//   fifo_wr, fifo_rd    per-channel FIFO write/read strobes
//   freeze              hold histograms, high-water marks and sat flags
//   clear               synchronous clear of histograms, high-water, sat flags
//   rd_en, rd_ch,       registered readout request: channel, selector
//   rd_sel, rd_bin      (0 gap hist, 1 occ hist, 2 high-water, 3 occ) and bin
//   rd_valid, rd_data   readout response, one cycle after the request
//   occ, gap            live occupancy / gap, channel c at [c*VAL_W +: VAL_W]
//   sat_flag            sticky per-channel histogram saturation flag
module fifo_stat_monitor #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned NUM_BINS  = 16,
   parameter int unsigned BIN_SHIFT = 3,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned VAL_W     = 16,
   localparam int unsigned DATA_W   = (CNT_W > VAL_W) ? CNT_W : VAL_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     run_program,
   input  logic                     active_program,
   input  logic                     end_program,
   input  logic [NUM_CH-1:0]        fifo_wr,
   input  logic [NUM_CH-1:0]        fifo_rd,
   input  logic                     freeze,
   input  logic                     clear,
   input  logic                     rd_en,
   input  logic [2:0]               rd_ch,
   input  logic [1:0]               rd_sel,
   input  logic [5:0]               rd_bin,
   output logic                     rd_valid,
   output logic [DATA_W-1:0]        rd_data,
   output logic [NUM_CH*VAL_W-1:0]  occ,
   output logic [NUM_CH*VAL_W-1:0]  gap,
   output logic [NUM_CH-1:0]        sat_flag
);

   localparam int unsigned BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

   logic [VAL_W-1:0]  occ_q      [NUM_CH];
   logic [VAL_W-1:0]  gap_q      [NUM_CH];
   logic [VAL_W-1:0]  hw_q       [NUM_CH];
   logic [CNT_W-1:0]  gap_hist_q [NUM_CH][NUM_BINS];
   logic [CNT_W-1:0]  occ_hist_q [NUM_CH][NUM_BINS];
   logic [NUM_CH-1:0] first_write_q;
   logic [NUM_CH-1:0] sat_q;
   logic [NUM_CH-1:0] sample;
   logic [BIN_W-1:0]  gap_bin    [NUM_CH];
   logic [BIN_W-1:0]  occ_bin    [NUM_CH];
   logic              start;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   // Bin width is 2^BIN_SHIFT; everything past the last bin lands in it.
   function automatic logic [BIN_W-1:0] bin_of(input logic [VAL_W-1:0] v);
      logic [VAL_W-1:0] s;
      s = v >> BIN_SHIFT;
      if (s > VAL_W'(NUM_BINS - 1)) begin
         return BIN_W'(NUM_BINS - 1);
      end
      return s[BIN_W-1:0];
   endfunction

   assign start = run_program && !active_program;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      // first_write_q is the pre-update value, so a channel's first write
      // after start only arms sampling and is not itself sampled.
      assign sample[c]  = fifo_wr[c] && active_program && first_write_q[c];
      assign gap_bin[c] = bin_of(gap_q[c]);
      assign occ_bin[c] = bin_of(occ_q[c]);
      assign occ[c*VAL_W +: VAL_W] = occ_q[c];
      assign gap[c*VAL_W +: VAL_W] = gap_q[c];
   end

   assign sat_flag = sat_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         first_write_q <= '0;
         sat_q         <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            occ_q[c] <= '0;
            gap_q[c] <= '0;
            hw_q[c]  <= '0;
            for (int b = 0; b < NUM_BINS; b++) begin
               gap_hist_q[c][b] <= '0;
               occ_hist_q[c][b] <= '0;
            end
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (start) begin
               occ_q[c]         <= '0;
               gap_q[c]         <= '0;
               hw_q[c]          <= '0;
               first_write_q[c] <= 1'b0;
               sat_q[c]         <= 1'b0;
               for (int b = 0; b < NUM_BINS; b++) begin
                  gap_hist_q[c][b] <= '0;
                  occ_hist_q[c][b] <= '0;
               end
            end else begin
               // Occupancy tracks the strobes regardless of freeze/active.
               if (fifo_wr[c] && !fifo_rd[c] && (occ_q[c] != '1)) begin
                  occ_q[c] <= occ_q[c] + 1'b1;
               end else if (fifo_rd[c] && !fifo_wr[c] && (occ_q[c] != '0)) begin
                  occ_q[c] <= occ_q[c] - 1'b1;
               end

               if (end_program || fifo_wr[c]) begin
                  gap_q[c] <= '0;
               end else if ((gap_q[c] != '1) && active_program && first_write_q[c]) begin
                  gap_q[c] <= gap_q[c] + 1'b1;
               end

               if (fifo_wr[c] && active_program) begin
                  first_write_q[c] <= 1'b1;
               end

               if (clear) begin
                  hw_q[c]  <= '0;
                  sat_q[c] <= 1'b0;
                  for (int b = 0; b < NUM_BINS; b++) begin
                     gap_hist_q[c][b] <= '0;
                     occ_hist_q[c][b] <= '0;
                  end
               end else if (!freeze) begin
                  if (occ_q[c] > hw_q[c]) begin
                     hw_q[c] <= occ_q[c];
                  end
                  if (sample[c]) begin
                     if (gap_hist_q[c][gap_bin[c]] == '1) begin
                        sat_q[c] <= 1'b1;
                     end else begin
                        gap_hist_q[c][gap_bin[c]] <= gap_hist_q[c][gap_bin[c]] + 1'b1;
                     end
                     if (occ_hist_q[c][occ_bin[c]] == '1) begin
                        sat_q[c] <= 1'b1;
                     end else begin
                        occ_hist_q[c][occ_bin[c]] <= occ_hist_q[c][occ_bin[c]] + 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   // Readout mux: out-of-range channel or bin leaves the data at zero.
   always_comb begin
      rd_data_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_ch == 3'(c)) begin
            case (rd_sel)
               2'd0: begin
                  for (int b = 0; b < NUM_BINS; b++) begin
                     if (rd_bin == 6'(b)) rd_data_d = DATA_W'(gap_hist_q[c][b]);
                  end
               end
               2'd1: begin
                  for (int b = 0; b < NUM_BINS; b++) begin
                     if (rd_bin == 6'(b)) rd_data_d = DATA_W'(occ_hist_q[c][b]);
                  end
               end
               2'd2:    rd_data_d = DATA_W'(hw_q[c]);
               default: rd_data_d = DATA_W'(occ_q[c]);
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_en;
         rd_data_q  <= rd_en ? rd_data_d : '0;
      end
   end

endmodule
